beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//  Sequences song playback for the main game datapath.
//  - Divides clk down to a difficulty-dependent beat period and runs a pre-roll countdown.
//  - Steps a beat index through the two edited note lanes, emitting one-cycle beat strobes
//    and the current lane bits, plus a one-cycle finish pulse after the last beat.
//  - Slaves to the state FSM mode code; freezes on PAUSE, aborts when the mode leaves RUN/PAUSE.
// PARAMETERS
//  SONG_LEN    32        beats per song; lane word width
//  DIV_W       23        beat divider counter width
//  EASY_DIV    23'd6000000  clk cycles per beat, level 0 (also level 3)
//  MED_DIV     23'd4000000  clk cycles per beat, level 1
//  HARD_DIV    23'd2000000  clk cycles per beat, level 2
//  CD_BEATS    3         countdown beats before song beat 0
// PORTS
//  clk         in   1         system clock
//  n_rst       in   1         reset; synchronous, ACTIVE-HIGH (1 = reset)
//  mode        in   3         state FSM code: 1 IDLE, 2 EDIT, 3 DIFF, 4 RUN, 5 PAUSE, 6 FINISH
//  level       in   2         difficulty: 0 easy, 1 medium, 2 hard, 3 treated as easy
//  notes1      in   SONG_LEN  lane 1 pattern, bit i = beat i
//  notes2      in   SONG_LEN  lane 2 pattern
//  beat_clk    out  1         one-cycle strobe per song beat
//  cd_tick     out  1         one-cycle strobe per countdown beat
//  counting    out  1         high while in COUNTDOWN or CD_HOLD
//  position    out  $clog2(SONG_LEN)  index of the most recently issued beat
//  note1       out  1         notes1[position], updated with beat_clk
//  note2       out  1         notes2[position], updated with beat_clk
//  finish      out  1         one-cycle pulse, song complete
//  busy        out  1         high in COUNTDOWN, CD_HOLD, PLAY, HOLD
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, div_cnt = 0, beat_idx = 0, cd_cnt = 0. Reset dominates every other event.
//  States: IDLE, COUNTDOWN, CD_HOLD, PLAY, HOLD, DONE.
//  IDLE: on mode==RUN, do all of the following at once:
//   - latch period from level (snapshot; later level changes ignored until the next run);
//   - clear div_cnt, cd_cnt and beat_idx; clear position, note1 and note2;
//   - go to COUNTDOWN (or directly to PLAY if CD_BEATS==0).
//  Divider (COUNTDOWN and PLAY only):
//   - div_cnt increments each cycle;
//   - at div_cnt == period-1 (terminal) it wraps to 0 and a beat event fires.
//   - Periods below 2 are clamped to 2.
//  Beat event in COUNTDOWN:
//   - cd_tick = 1 next cycle and cd_cnt++;
//   - on the CD_BEATS-th event go to PLAY; div_cnt continues from 0.
//  Beat event in PLAY with beat_idx < SONG_LEN:
//   - registered next cycle: beat_clk = 1, position = beat_idx, note1 = notes1[beat_idx], note2 = notes2[beat_idx];
//   - beat_idx++.
//  Beat event in PLAY with beat_idx == SONG_LEN: finish = 1 next cycle; go to DONE.
//  Latency: terminal cycle to strobe = 1 clk. All strobes deassert after exactly 1 cycle.
//  Pause:
//   - mode==PAUSE in PLAY -> HOLD; in COUNTDOWN -> CD_HOLD. div_cnt is frozen, no strobes, outputs hold.
//   - mode==RUN returns to the saved state; div_cnt resumes from its frozen value.
//   - PAUSE arriving on a terminal cycle wins: no event fires, div_cnt holds period-1, and the event fires on the first resumed cycle.
//  Abort: mode not RUN/PAUSE while busy -> IDLE. No finish; position, note1 and note2 are cleared.
//  DONE: outputs hold, no strobes. Exit to IDLE when mode != RUN. Re-entering RUN from IDLE starts a fresh song.
//  Wrap: beat_idx has width $clog2(SONG_LEN)+1 so the value SONG_LEN is representable; position never exceeds SONG_LEN-1.
//  notes1 and notes2 are sampled live at each beat event; edits made mid-song take effect at the next beat.
// TESTING  (SONG_LEN=4, EASY_DIV=4, MED_DIV=3, HARD_DIV=2, CD_BEATS=2; cycle 0 = first edge sampling mode=RUN)
//  T1 reset: n_rst=1 for 2 cycles, mode=RUN, level=2 -> all outputs 0, no strobes while n_rst=1.
//  T2 easy run, notes1=4'b0101, notes2=4'b1000:
//   - cd_tick after edges 4 and 8;
//   - beat_clk after edges 12, 16, 20, 24 with (position, note1, note2) = (0,1,0), (1,0,0), (2,1,0), (3,0,1);
//   - finish after edge 28 only, then busy=0.
//  T3 hard run, level changed to 0 at cycle 5 -> beats every 2 cycles: beat_clk at 6, 8, 10, 12; finish at 14.
//  T4 pause: easy run, mode=PAUSE cycles 13-22, then RUN -> second beat_clk delayed by 10 cycles to edge 26; position and notes held during the pause.
//  T5 pause on terminal: PAUSE asserted on the cycle with div_cnt=3 -> no strobe while paused; strobe 1 cycle after the first resumed edge.
//  T6 abort and reset mid-run:
//   - mode=IDLE after edge 17 -> no finish, position=0, busy=0; a following RUN restarts the countdown;
//   - n_rst=1 at edge 18 during PLAY -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/beat_sequencer.sv
// ---------------------------------------------------------------------------
// beat_sequencer
//
// Purpose:
//   Sequences song playback for the main game datapath. The system clock is
//   divided down to a difficulty-dependent beat period. A short pre-roll
//   countdown runs first. Then a beat index steps through the two edited
//   note lanes. Each beat emits a one-cycle strobe together with the lane
//   bits for that beat. A one-cycle finish pulse follows the last beat.
//   The block follows the game state FSM mode code: it freezes on PAUSE and
//   aborts when the mode leaves RUN/PAUSE.
//
// Ports:
//   clk       in   system clock
//   n_rst     in   synchronous reset, active high (1 = reset)
//   mode      in   state FSM code: 1 IDLE, 2 EDIT, 3 DIFF, 4 RUN, 5 PAUSE, 6 FINISH
//   level     in   difficulty: 0 easy, 1 medium, 2 hard, 3 treated as easy
//   notes1    in   lane 1 pattern, bit i = beat i
//   notes2    in   lane 2 pattern, bit i = beat i
//   beat_clk  out  one-cycle strobe per song beat
//   cd_tick   out  one-cycle strobe per countdown beat
//   counting  out  high while the countdown is running or paused
//   position  out  index of the most recently issued beat
//   note1     out  notes1[position], updated together with beat_clk
//   note2     out  notes2[position], updated together with beat_clk
//   finish    out  one-cycle pulse when the song is complete
//   busy      out  high while a countdown or song is running or paused
// ---------------------------------------------------------------------------
module beat_sequencer #(
   parameter int               SONG_LEN = 32,
   parameter int               DIV_W    = 23,
   parameter logic [DIV_W-1:0] EASY_DIV = 23'd6000000,
   parameter logic [DIV_W-1:0] MED_DIV  = 23'd4000000,
   parameter logic [DIV_W-1:0] HARD_DIV = 23'd2000000,
   parameter int               CD_BEATS = 3
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [2:0]                  mode,
   input  logic [1:0]                  level,
   input  logic [SONG_LEN-1:0]         notes1,
   input  logic [SONG_LEN-1:0]         notes2,
   output logic                        beat_clk,
   output logic                        cd_tick,
   output logic                        counting,
   output logic [$clog2(SONG_LEN)-1:0] position,
   output logic                        note1,
   output logic                        note2,
   output logic                        finish,
   output logic                        busy
);

   localparam int POS_W = $clog2(SONG_LEN);
   // One extra bit so the index can hold SONG_LEN itself, which marks "all beats issued".
   localparam int IDX_W = POS_W + 1;
   localparam int CD_W  = (CD_BEATS < 2) ? 1 : $clog2(CD_BEATS + 1);

   localparam logic [2:0] MODE_RUN   = 3'd4;
   localparam logic [2:0] MODE_PAUSE = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNTDOWN,
      S_CD_HOLD,
      S_PLAY,
      S_HOLD,
      S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    div_cnt, div_nxt;
   logic [DIV_W-1:0]    period, period_nxt;
   logic [CD_W-1:0]     cd_cnt, cd_nxt;
   logic [IDX_W-1:0]    beat_idx, idx_nxt;
   logic [POS_W-1:0]    pos_nxt;
   logic                note1_nxt, note2_nxt;
   logic                beat_nxt, cd_tick_nxt, finish_nxt;
   logic [DIV_W-1:0]    raw_period, level_period;
   logic                terminal;
   logic [DIV_W-1:0]    div_step;

   // Pick the beat period for the requested difficulty. Level 3 has no
   // table entry of its own and plays as easy. Anything below 2 is clamped,
   // so the divider always has a distinct terminal cycle.
   always_comb begin
      raw_period = EASY_DIV;
      case (level)
         2'd1:    raw_period = MED_DIV;
         2'd2:    raw_period = HARD_DIV;
         default: raw_period = EASY_DIV;
      endcase
      level_period = (raw_period < DIV_W'(2)) ? DIV_W'(2) : raw_period;
   end

   // Next-state and next-output logic. Every register holds by default and
   // all strobes default low. The two paused states share their branch with
   // the running state they came from. A RUN sampled while paused is
   // therefore handled exactly like a running cycle, so the divider resumes
   // counting on that same edge. A PAUSE that lands on the terminal cycle
   // leaves div_cnt at period-1. The beat then fires on the first resumed
   // cycle.
   always_comb begin
      state_nxt   = state;
      div_nxt     = div_cnt;
      period_nxt  = period;
      cd_nxt      = cd_cnt;
      idx_nxt     = beat_idx;
      pos_nxt     = position;
      note1_nxt   = note1;
      note2_nxt   = note2;
      beat_nxt    = 1'b0;
      cd_tick_nxt = 1'b0;
      finish_nxt  = 1'b0;

      terminal = (div_cnt == period - 1'b1);
      div_step = terminal ? '0 : div_cnt + 1'b1;

      case (state)
         S_IDLE: begin
            if (mode == MODE_RUN) begin
               period_nxt = level_period;
               div_nxt    = '0;
               cd_nxt     = '0;
               idx_nxt    = '0;
               pos_nxt    = '0;
               note1_nxt  = 1'b0;
               note2_nxt  = 1'b0;
               state_nxt  = (CD_BEATS == 0) ? S_PLAY : S_COUNTDOWN;
            end
         end

         S_COUNTDOWN, S_CD_HOLD: begin
            if (mode == MODE_RUN) begin
               state_nxt = S_COUNTDOWN;
               div_nxt   = div_step;
               if (terminal) begin
                  cd_tick_nxt = 1'b1;
                  cd_nxt      = cd_cnt + 1'b1;
                  if (cd_cnt == CD_W'(CD_BEATS - 1)) begin
                     state_nxt = S_PLAY;
                  end
               end
            end else if (mode == MODE_PAUSE) begin
               state_nxt = S_CD_HOLD;
            end else begin
               state_nxt = S_IDLE;
               pos_nxt   = '0;
               note1_nxt = 1'b0;
               note2_nxt = 1'b0;
            end
         end

         S_PLAY, S_HOLD: begin
            if (mode == MODE_RUN) begin
               state_nxt = S_PLAY;
               div_nxt   = div_step;
               if (terminal) begin
                  if (beat_idx == IDX_W'(SONG_LEN)) begin
                     finish_nxt = 1'b1;
                     state_nxt  = S_DONE;
                  end else begin
                     beat_nxt  = 1'b1;
                     pos_nxt   = beat_idx[POS_W-1:0];
                     note1_nxt = notes1[beat_idx[POS_W-1:0]];
                     note2_nxt = notes2[beat_idx[POS_W-1:0]];
                     idx_nxt   = beat_idx + 1'b1;
                  end
               end
            end else if (mode == MODE_PAUSE) begin
               state_nxt = S_HOLD;
            end else begin
               state_nxt = S_IDLE;
               pos_nxt   = '0;
               note1_nxt = 1'b0;
               note2_nxt = 1'b0;
            end
         end

         S_DONE: begin
            if (mode != MODE_RUN) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset has priority over everything and
   // clears all outputs and counters.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         period   <= '0;
         cd_cnt   <= '0;
         beat_idx <= '0;
         position <= '0;
         note1    <= 1'b0;
         note2    <= 1'b0;
         beat_clk <= 1'b0;
         cd_tick  <= 1'b0;
         finish   <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_nxt;
         period   <= period_nxt;
         cd_cnt   <= cd_nxt;
         beat_idx <= idx_nxt;
         position <= pos_nxt;
         note1    <= note1_nxt;
         note2    <= note2_nxt;
         beat_clk <= beat_nxt;
         cd_tick  <= cd_tick_nxt;
         finish   <= finish_nxt;
      end
   end

   // The status flags are decoded directly from the registered state, so
   // they change on the same edge as the state itself.
   assign counting = (state == S_COUNTDOWN) || (state == S_CD_HOLD);
   assign busy     = counting || (state == S_PLAY) || (state == S_HOLD);

endmodule

// File: tb/tb_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beat_sequencer
//
// Purpose:
//   Self-checking bench for beat_sequencer. It uses a small song, a short
//   divider and a short countdown. Every cycle is compared against a
//   behavioural model. The model counts "active" cycles (edges that sample
//   mode == RUN) since the song started. Event number n fires when that
//   count reaches n * period. The first CD_BEATS events are countdown
//   ticks, the next SONG_LEN events are beats, and the event after those is
//   the finish pulse.
// ---------------------------------------------------------------------------
module tb_beat_sequencer;

   localparam int SONG_LEN = 4;
   localparam int CD_BEATS = 2;

   localparam logic [2:0] M_IDLE   = 3'd1;
   localparam logic [2:0] M_EDIT   = 3'd2;
   localparam logic [2:0] M_DIFF   = 3'd3;
   localparam logic [2:0] M_RUN    = 3'd4;
   localparam logic [2:0] M_PAUSE  = 3'd5;
   localparam logic [2:0] M_FINISH = 3'd6;

   logic       clk;
   logic       n_rst;
   logic [2:0] mode;
   logic [1:0] level;
   logic [3:0] notes1;
   logic [3:0] notes2;
   logic       beat_clk;
   logic       cd_tick;
   logic       counting;
   logic [1:0] position;
   logic       note1;
   logic       note2;
   logic       finish;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit         m_running;
   bit         m_done;
   int         m_t;
   int         m_period;
   logic [1:0] m_pos;
   bit         m_n1;
   bit         m_n2;
   bit         m_beat;
   bit         m_cd;
   bit         m_fin;

   beat_sequencer #(
      .SONG_LEN (SONG_LEN),
      .DIV_W    (23),
      .EASY_DIV (23'd4),
      .MED_DIV  (23'd3),
      .HARD_DIV (23'd2),
      .CD_BEATS (CD_BEATS)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .mode     (mode),
      .level    (level),
      .notes1   (notes1),
      .notes2   (notes2),
      .beat_clk (beat_clk),
      .cd_tick  (cd_tick),
      .counting (counting),
      .position (position),
      .note1    (note1),
      .note2    (note2),
      .finish   (finish),
      .busy     (busy)
   );

   // Free-running clock with a 10-time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int period_of(input logic [1:0] lv);
      if (lv == 2'd1) return 3;
      if (lv == 2'd2) return 2;
      return 4;
   endfunction

   function automatic logic [8:0] dut_vec();
      return {beat_clk, cd_tick, counting, position, note1, note2, finish, busy};
   endfunction

   function automatic logic [8:0] exp_vec();
      logic cnt;
      cnt = m_running && (m_t < CD_BEATS * m_period);
      return {m_beat, m_cd, cnt, m_pos, m_n1, m_n2, m_fin, m_running};
   endfunction

   // Advance the model by one clock edge, using the inputs sampled at that edge
   task automatic model_edge();
      int e;
      int k;
      m_beat = 0;
      m_cd   = 0;
      m_fin  = 0;
      if (n_rst) begin
         m_running = 0;
         m_done    = 0;
         m_t       = 0;
         m_pos     = '0;
         m_n1      = 0;
         m_n2      = 0;
      end else if (m_running) begin
         if (mode == M_RUN) begin
            m_t++;
            if (m_t % m_period == 0) begin
               e = m_t / m_period;
               if (e <= CD_BEATS) begin
                  m_cd = 1;
               end else if (e <= CD_BEATS + SONG_LEN) begin
                  k      = e - CD_BEATS - 1;
                  m_beat = 1;
                  m_pos  = k[1:0];
                  m_n1   = notes1[k];
                  m_n2   = notes2[k];
               end else begin
                  m_fin     = 1;
                  m_running = 0;
                  m_done    = 1;
               end
            end
         end else if (mode != M_PAUSE) begin
            m_running = 0;
            m_pos     = '0;
            m_n1      = 0;
            m_n2      = 0;
         end
      end else if (m_done) begin
         if (mode != M_RUN) m_done = 0;
      end else if (mode == M_RUN) begin
         m_running = 1;
         m_t       = 0;
         m_period  = period_of(level);
         m_pos     = '0;
         m_n1      = 0;
         m_n2      = 0;
      end
   endtask

   // Drive one cycle of inputs on the falling edge, update the model at the
   // rising edge, and leave time 1 unit after that edge for sampling
   task automatic apply_stimulus(input logic rst, input logic [2:0] m,
                                 input logic [1:0] lv, input logic [3:0] a,
                                 input logic [3:0] b);
      @(negedge clk);
      n_rst  = rst;
      mode   = m;
      level  = lv;
      notes1 = a;
      notes2 = b;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Put both DUT and model into a clean idle state before a scenario
   task automatic start_fresh();
      apply_stimulus(1'b1, M_IDLE, 2'd0, 4'd0, 4'd0);
      apply_stimulus(1'b0, M_IDLE, 2'd0, 4'd0, 4'd0);
   endtask

   // Reset held with RUN requested must keep every output low
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(1'b1, M_RUN, 2'd2, 4'hF, 4'hF);
         vectors++;
         if (dut_vec() !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL reset cyc %0d: got %b want %b", i, dut_vec(), 9'b0);
         end
      end
   endtask

   // Full easy-level song with fixed lanes; checks strobe timing and lane bits
   task automatic test_easy_run();
      logic [63:0] beat_mask, cd_mask, fin_mask;
      logic [3:0]  tbl [4];
      int          j;
      tbl       = '{4'b0010, 4'b0100, 4'b1010, 4'b1101};
      beat_mask = '0;
      cd_mask   = '0;
      fin_mask  = '0;
      j         = 0;
      start_fresh();
      for (int i = 0; i < 32; i++) begin
         apply_stimulus(1'b0, M_RUN, 2'd0, 4'b0101, 4'b1000);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL easy_run cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
         if (beat_clk === 1'b1) begin
            beat_mask[i] = 1'b1;
            if (j < 4) begin
               vectors++;
               if ({position, note1, note2} !== tbl[j]) begin
                  miscompares++;
                  $display("[TB] FAIL easy_beat%0d: got %b want %b", j, {position, note1, note2}, tbl[j]);
               end
            end
            j++;
         end
         if (cd_tick === 1'b1) cd_mask[i] = 1'b1;
         if (finish === 1'b1) fin_mask[i] = 1'b1;
      end
      vectors++;
      if (beat_mask !== ((64'd1 << 12) | (64'd1 << 16) | (64'd1 << 20) | (64'd1 << 24))) begin
         miscompares++;
         $display("[TB] FAIL easy_beat_edges: got %h want %h", beat_mask, 64'h0111_1000);
      end
      vectors++;
      if (cd_mask !== ((64'd1 << 4) | (64'd1 << 8))) begin
         miscompares++;
         $display("[TB] FAIL easy_cd_edges: got %h want %h", cd_mask, 64'h110);
      end
      vectors++;
      if (fin_mask !== (64'd1 << 28) || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL easy_finish: got %h busy %b want %h busy 0", fin_mask, busy, 64'h1000_0000);
      end
   endtask

   // Hard level; a level change mid-run must be ignored
   task automatic test_hard_run();
      logic [63:0] beat_mask, fin_mask;
      beat_mask = '0;
      fin_mask  = '0;
      start_fresh();
      for (int i = 0; i < 18; i++) begin
         apply_stimulus(1'b0, M_RUN, (i >= 5) ? 2'd0 : 2'd2, 4'b0110, 4'b1001);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL hard_run cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
         if (beat_clk === 1'b1) beat_mask[i] = 1'b1;
         if (finish === 1'b1) fin_mask[i] = 1'b1;
      end
      vectors++;
      if (beat_mask !== ((64'd1 << 6) | (64'd1 << 8) | (64'd1 << 10) | (64'd1 << 12)) ||
          fin_mask !== (64'd1 << 14)) begin
         miscompares++;
         $display("[TB] FAIL hard_edges: got beats %h fin %h want beats %h fin %h",
                  beat_mask, fin_mask, 64'h1540, 64'h4000);
      end
   endtask

   // Pause during play delays the following beats by the pause length
   task automatic test_pause();
      logic [63:0] beat_mask, fin_mask;
      beat_mask = '0;
      fin_mask  = '0;
      start_fresh();
      for (int i = 0; i < 42; i++) begin
         apply_stimulus(1'b0, (i >= 13 && i <= 22) ? M_PAUSE : M_RUN, 2'd0, 4'b0101, 4'b1000);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL pause cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
         if (beat_clk === 1'b1) beat_mask[i] = 1'b1;
         if (finish === 1'b1) fin_mask[i] = 1'b1;
      end
      vectors++;
      if (beat_mask !== ((64'd1 << 12) | (64'd1 << 26) | (64'd1 << 30) | (64'd1 << 34)) ||
          fin_mask !== (64'd1 << 38)) begin
         miscompares++;
         $display("[TB] FAIL pause_edges: got beats %h fin %h", beat_mask, fin_mask);
      end
   endtask

   // Pause sampled on the terminal divider cycle: the tick moves to the first resumed edge
   task automatic test_pause_terminal();
      logic [63:0] cd_mask;
      cd_mask = '0;
      start_fresh();
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(1'b0, (i >= 4 && i <= 7) ? M_PAUSE : M_RUN, 2'd3, 4'b0011, 4'b0100);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL pause_term cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
         if (cd_tick === 1'b1) cd_mask[i] = 1'b1;
      end
      vectors++;
      if (cd_mask !== ((64'd1 << 8) | (64'd1 << 12))) begin
         miscompares++;
         $display("[TB] FAIL pause_term_edges: got %h want %h", cd_mask, 64'h1100);
      end
   endtask

   // Abort mid-song, restart, then reset in the middle of play
   task automatic test_abort();
      logic [63:0] cd_mask;
      logic [2:0]  m;
      cd_mask = '0;
      start_fresh();
      for (int i = 0; i < 28; i++) begin
         m = (i >= 18 && i <= 20) ? M_IDLE : M_RUN;
         apply_stimulus(1'b0, m, 2'd0, 4'b0111, 4'b1010);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL abort cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
         if (i == 18) begin
            vectors++;
            if ({finish, position, note1, note2, busy} !== 6'b0) begin
               miscompares++;
               $display("[TB] FAIL abort_clear: got %b want %b", {finish, position, note1, note2, busy}, 6'b0);
            end
         end
         if (cd_tick === 1'b1) cd_mask[i] = 1'b1;
      end
      vectors++;
      if (cd_mask !== ((64'd1 << 4) | (64'd1 << 8) | (64'd1 << 25))) begin
         miscompares++;
         $display("[TB] FAIL abort_restart: got %h want %h", cd_mask, 64'h200_0110);
      end
      start_fresh();
      for (int i = 0; i < 19; i++) begin
         apply_stimulus((i == 18) ? 1'b1 : 1'b0, M_RUN, 2'd0, 4'b1111, 4'b1111);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL mid_reset cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
      end
      vectors++;
      if (dut_vec() !== 9'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_zero: got %b want %b", dut_vec(), 9'b0);
      end
   endtask

   // A song finishes, the mode leaves RUN briefly, and a second song follows at once
   task automatic test_back_to_back();
      logic [63:0] fin_mask;
      fin_mask = '0;
      start_fresh();
      for (int i = 0; i < 32; i++) begin
         apply_stimulus(1'b0, (i == 15) ? M_FINISH : M_RUN, 2'd2, 4'b1100, 4'b0011);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL b2b cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
         if (finish === 1'b1) fin_mask[i] = 1'b1;
      end
      vectors++;
      if (fin_mask !== ((64'd1 << 14) | (64'd1 << 30))) begin
         miscompares++;
         $display("[TB] FAIL b2b_finish: got %h want %h", fin_mask, 64'h4000_4000);
      end
   endtask

   // Randomized modes, levels, lane edits and occasional resets
   task automatic test_random();
      logic       rst;
      logic [2:0] m;
      logic [1:0] lv;
      logic [3:0] a, b;
      int         r;
      logic [2:0] others [4];
      others = '{M_IDLE, M_EDIT, M_DIFF, M_FINISH};
      a = 4'($urandom);
      b = 4'($urandom);
      start_fresh();
      for (int i = 0; i < 600; i++) begin
         r   = $urandom_range(0, 99);
         rst = ($urandom_range(0, 299) == 0);
         if (r < 85)      m = M_RUN;
         else if (r < 98) m = M_PAUSE;
         else             m = others[$urandom_range(0, 3)];
         lv = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 4'($urandom);
         if ($urandom_range(0, 7) == 0) b = 4'($urandom);
         apply_stimulus(rst, m, lv, a, b);
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL random cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      n_rst  = 1'b1;
      mode   = M_IDLE;
      level  = 2'd0;
      notes1 = 4'd0;
      notes2 = 4'd0;
      test_reset();
      test_easy_run();
      test_hard_run();
      test_pause();
      test_pause_terminal();
      test_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
